// File: rtl/muldiv_issue_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_issue_ctrl
// Issues one M-extension MUL/DIV/REM op at a time to the multi-cycle mul/div
// unit and returns the result with its destination index to writeback.
// RISC-V divide special cases (divide by zero, signed overflow) are resolved
// locally without touching the unit.
//
// Ports:
//   clock, reset          clock; asynchronous active-high reset
//   req_*                 decoded op from execute (valid/ready handshake)
//   flush                 kill the accepted/in-flight op, no writeback
//   mu_*                  unit interface; operands held stable from latches
//   wb_*                  result to writeback (valid/ready handshake)
//   busy                  controller not idle
//   last_latency          RUN cycles taken by the last completed unit op
//   err_timeout           sticky; RUN lasted longer than WAIT_LIMIT cycles
//
// Optional feature: define MULDIV_RESULT_CACHE_EN for a one-entry result
// cache that lets a repeated op bypass the unit.
// ---------------------------------------------------------------------------
module muldiv_issue_ctrl #(
   parameter int unsigned WAIT_LIMIT = 64,
   parameter int unsigned CNT_W      = 7
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_funct3,
   input  logic [31:0]      req_rs1,
   input  logic [31:0]      req_rs2,
   input  logic [4:0]       req_rd,
   input  logic             flush,
   output logic             mu_enabled,
   output logic [2:0]       mu_funct3,
   output logic [31:0]      mu_rs1,
   output logic [31:0]      mu_rs2,
   input  logic [31:0]      mu_rd,
   input  logic             mu_wait,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [4:0]       wb_rd,
   output logic [31:0]      wb_data,
   output logic             busy,
   output logic [CNT_W-1:0] last_latency,
   output logic             err_timeout
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_WB    = 2'd3;

   localparam logic [2:0] F_DIV  = 3'd4;
   localparam logic [2:0] F_DIVU = 3'd5;
   localparam logic [2:0] F_REM  = 3'd6;
   localparam logic [2:0] F_REMU = 3'd7;

   localparam logic [31:0]      INT_MIN  = 32'h8000_0000;
   localparam logic [31:0]      ALL_ONES = 32'hFFFF_FFFF;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(WAIT_LIMIT);

   logic [1:0]       state, state_next;
   logic [2:0]       funct3_q;
   logic [31:0]      rs1_q, rs2_q, wb_data_q;
   logic [4:0]       rd_q;
   logic [CNT_W-1:0] cnt, cnt_next, cnt_inc, last_lat_q;
   logic             err_q;

   logic             accept, result_load, lat_load, err_set;
   logic [31:0]      result_next;
   logic             special;
   logic [31:0]      special_result;
   logic             cache_hit;
   logic [31:0]      cached_result;

   assign req_ready    = (state == S_IDLE);
   assign busy         = (state != S_IDLE);
   assign mu_enabled   = (state == S_RUN) || (state == S_DRAIN);
   assign wb_valid     = (state == S_WB);
   assign mu_funct3    = funct3_q;
   assign mu_rs1       = rs1_q;
   assign mu_rs2       = rs2_q;
   assign wb_rd        = rd_q;
   assign wb_data      = wb_data_q;
   assign last_latency = last_lat_q;
   assign err_timeout  = err_q;

   // Divide special cases decoded straight from the offered request
   always_comb begin
      special        = 1'b0;
      special_result = '0;
      if (((req_funct3 == F_DIV) || (req_funct3 == F_DIVU)) && (req_rs2 == '0)) begin
         special        = 1'b1;
         special_result = ALL_ONES;
      end else if (((req_funct3 == F_REM) || (req_funct3 == F_REMU)) && (req_rs2 == '0)) begin
         special        = 1'b1;
         special_result = req_rs1;
      end else if ((req_funct3 == F_DIV) && (req_rs1 == INT_MIN) && (req_rs2 == ALL_ONES)) begin
         special        = 1'b1;
         special_result = INT_MIN;
      end else if ((req_funct3 == F_REM) && (req_rs1 == INT_MIN) && (req_rs2 == ALL_ONES)) begin
         special        = 1'b1;
         special_result = '0;
      end
   end

`ifdef MULDIV_RESULT_CACHE_EN
   logic        cache_valid;
   logic [2:0]  cache_funct3;
   logic [31:0] cache_rs1, cache_rs2, cache_data;

   assign cache_hit     = cache_valid && (cache_funct3 == req_funct3) &&
                          (cache_rs1 == req_rs1) && (cache_rs2 == req_rs2);
   assign cached_result = cache_data;
`else
   assign cache_hit     = 1'b0;
   assign cached_result = '0;
`endif

   // Saturating so a hung unit cannot wrap the counter back under the limit
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next state and datapath strobes
   always_comb begin
      state_next  = state;
      accept      = 1'b0;
      result_load = 1'b0;
      result_next = wb_data_q;
      lat_load    = 1'b0;
      err_set     = 1'b0;
      cnt_next    = cnt;
      case (state)
         S_IDLE: begin
            if (req_valid && !flush) begin
               accept = 1'b1;
               if (special || cache_hit) begin
                  result_load = 1'b1;
                  result_next = special ? special_result : cached_result;
                  state_next  = (req_rd == '0) ? S_IDLE : S_WB;
               end else begin
                  cnt_next   = '0;
                  state_next = S_RUN;
               end
            end
         end
         S_RUN: begin
            cnt_next = cnt_inc;
            if (mu_wait && (cnt_inc >= CNT_LIM)) err_set = 1'b1;
            // A flush on the unit's answering cycle has nothing left to drain
            if (flush) begin
               state_next = mu_wait ? S_DRAIN : S_IDLE;
            end else if (!mu_wait) begin
               result_load = 1'b1;
               result_next = mu_rd;
               lat_load    = 1'b1;
               state_next  = (rd_q == '0) ? S_IDLE : S_WB;
            end
         end
         S_DRAIN: begin
            if (!mu_wait) state_next = S_IDLE;
         end
         S_WB: begin
            if (flush || wb_ready) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Operand latches, result, latency and error registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         funct3_q   <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         wb_data_q  <= '0;
         cnt        <= '0;
         last_lat_q <= '0;
         err_q      <= 1'b0;
      end else begin
         if (accept) begin
            funct3_q <= req_funct3;
            rs1_q    <= req_rs1;
            rs2_q    <= req_rs2;
            rd_q     <= req_rd;
         end
         cnt <= cnt_next;
         if (result_load) wb_data_q  <= result_next;
         if (lat_load)    last_lat_q <= cnt_next;
         if (err_set)     err_q      <= 1'b1;
      end
   end

`ifdef MULDIV_RESULT_CACHE_EN
   // Filled on every undiscarded unit completion
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cache_valid  <= 1'b0;
         cache_funct3 <= '0;
         cache_rs1    <= '0;
         cache_rs2    <= '0;
         cache_data   <= '0;
      end else if (lat_load) begin
         cache_valid  <= 1'b1;
         cache_funct3 <= funct3_q;
         cache_rs1    <= rs1_q;
         cache_rs2    <= rs2_q;
         cache_data   <= mu_rd;
      end
   end
`endif

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_muldiv_issue_ctrl
// Scoreboard bench for muldiv_issue_ctrl: a driver issues directed and random
// ops and queues the architectural RISC-V result, a behavioural unit answers
// after a planned number of wait cycles, and a monitor checks every
// writeback cycle against the queue. Honours MULDIV_RESULT_CACHE_EN.
// ---------------------------------------------------------------------------
module tb_muldiv_issue_ctrl;

   localparam int unsigned WAIT_LIMIT = 64;
   localparam int unsigned CNT_W      = 7;
   localparam logic [31:0] INT_MIN    = 32'h8000_0000;
   localparam logic [31:0] ALL_ONES   = 32'hFFFF_FFFF;

   logic             clock, reset;
   logic             req_valid, req_ready;
   logic [2:0]       req_funct3;
   logic [31:0]      req_rs1, req_rs2;
   logic [4:0]       req_rd;
   logic             flush;
   logic             mu_enabled;
   logic [2:0]       mu_funct3;
   logic [31:0]      mu_rs1, mu_rs2, mu_rd;
   logic             mu_wait;
   logic             wb_valid, wb_ready;
   logic [4:0]       wb_rd;
   logic [31:0]      wb_data;
   logic             busy;
   logic [CNT_W-1:0] last_latency;
   logic             err_timeout;

   muldiv_issue_ctrl #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
      .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .flush(flush),
      .mu_enabled(mu_enabled), .mu_funct3(mu_funct3), .mu_rs1(mu_rs1),
      .mu_rs2(mu_rs2), .mu_rd(mu_rd), .mu_wait(mu_wait),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
      .busy(busy), .last_latency(last_latency), .err_timeout(err_timeout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      bit          drop;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   // Reference model state
   bit          m_cache_valid = 0;
   logic [2:0]  m_cf3 = '0;
   logic [31:0] m_ca = '0, m_cb = '0;
   int          m_last_lat = 0;
   bit          m_err = 0;
   int          m_runs = 0;
   int          unit_runs = 0;
   int          plan_waits = 0;
   logic [2:0]  cur_f3 = '0;
   logic [31:0] cur_a = '0, cur_b = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural RISC-V M-extension result
   function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
      longint          ps;
      longint unsigned pu;
      logic signed [31:0] sa, sbv;
      sa  = a;
      sbv = b;
      case (f3)
         3'd0: begin pu = {32'd0, a} * {32'd0, b}; return pu[31:0]; end
         3'd1: begin ps = longint'(sa) * longint'(sbv); return ps[63:32]; end
         3'd2: begin ps = longint'(sa) * longint'({32'd0, b}); return ps[63:32]; end
         3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
         3'd4: begin
            if (b == 0) return ALL_ONES;
            if (a == INT_MIN && b == ALL_ONES) return INT_MIN;
            return sa / sbv;
         end
         3'd5: return (b == 0) ? ALL_ONES : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == INT_MIN && b == ALL_ONES) return 32'd0;
            return sa % sbv;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (f3 >= 3'd4 && b == 0) return 1'b1;
      if ((f3 == 3'd4 || f3 == 3'd6) && a == INT_MIN && b == ALL_ONES) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom % 6)
         0: return 32'd0;
         1: return INT_MIN;
         2: return ALL_ONES;
         3: return 32'($urandom % 20);
         default: return 32'($urandom);
      endcase
   endfunction

   // Behavioural mul/div unit: busy for plan_waits enabled cycles, then answers
   initial begin
      int  run_cnt;
      bit  prev_en;
      run_cnt = 0;
      prev_en = 0;
      mu_wait = 1'b0;
      mu_rd   = '0;
      forever begin
         @(posedge clock);
         #1;
         if (mu_enabled) begin
            if (!prev_en) begin
               unit_runs++;
               run_cnt = 0;
            end
            mu_wait = (run_cnt < plan_waits);
            run_cnt++;
            mu_rd = mu_wait ? 32'($urandom) : ref_result(mu_funct3, mu_rs1, mu_rs2);
         end else begin
            mu_wait = 1'($urandom);
            mu_rd   = 32'($urandom);
         end
         prev_en = mu_enabled;
      end
   end

   // Monitor: operand stability to the unit and writeback against the scoreboard
   always @(negedge clock) begin
      if (!reset) begin
         if (mu_enabled) begin
            check("mu_funct3", mu_funct3, cur_f3);
            check("mu_rs1", mu_rs1, cur_a);
            check("mu_rs2", mu_rs2, cur_b);
         end
         if (wb_valid) begin
            if (sb.size() == 0) begin
               check("wb_unexpected", wb_valid, 1'b0);
            end else begin
               check("wb_rd", wb_rd, sb[0].rd);
               check("wb_data", wb_data, sb[0].data);
               if (flush) begin
                  check("wb_flush_planned", sb[0].drop, 1'b1);
                  void'(sb.pop_front());
               end else if (wb_ready) begin
                  check("wb_after_flush", sb[0].drop, 1'b0);
                  void'(sb.pop_front());
               end
            end
         end
      end
   end

   // mode: 0 normal, 1 flush in RUN cycle flush_at, 2 flush in WB
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int waits, input int mode_in,
                         input int flush_at, input int stall);
      logic [31:0] exp;
      bit spec, hit, unit, wb_seen, done;
      int mode, edges, exp_lat, stall_left;
      exp  = ref_result(f3, a, b);
      spec = is_special(f3, a, b);
`ifdef MULDIV_RESULT_CACHE_EN
      hit = !spec && m_cache_valid && m_cf3 == f3 && m_ca == a && m_cb == b;
`else
      hit = 1'b0;
`endif
      unit = !spec && !hit;
      mode = mode_in;
      if (mode == 1 && (!unit || flush_at < 1 || flush_at > waits)) mode = 0;
      if (mode == 2 && rd == 0) mode = 0;
      exp_lat = unit ? waits + 2 : 1;

      @(negedge clock);
      check("req_ready_idle", req_ready, 1'b1);
      cur_f3 = f3; cur_a = a; cur_b = b;
      plan_waits = waits;
      req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b; req_rd = rd;
      flush = 1'b0; wb_ready = 1'b0;
      if (rd != 0 && mode != 1) sb.push_back('{rd: rd, data: exp, drop: (mode == 2)});
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      req_funct3 = 3'($urandom); req_rs1 = 32'($urandom); req_rs2 = 32'($urandom);
      req_rd = 5'($urandom);
      edges = 1; wb_seen = 0; done = 0;
      stall_left = (stall > 0) ? stall - 1 : 0;
      wb_ready = (stall == 0 && mode != 2) ? 1'($urandom) : 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clock);
         if (!busy) begin
            done = 1;
            break;
         end
         check("req_ready_busy", req_ready, 1'b0);
         if (mode == 1) check("mu_enabled_drain", mu_enabled, 1'b1);
         if (wb_valid && !wb_seen) begin
            wb_seen = 1;
            check("latency", edges, exp_lat);
         end
         @(posedge clock);
         #1;
         edges++;
         flush = (mode == 1 && edges == flush_at) || (mode == 2 && wb_seen);
         if (wb_seen) begin
            if (mode == 2) wb_ready = 1'($urandom);
            else if (stall_left > 0) begin wb_ready = 1'b0; stall_left--; end
            else wb_ready = 1'b1;
         end else begin
            wb_ready = (stall == 0 && mode != 2) ? 1'($urandom) : 1'b0;
         end
      end
      flush = 1'b0;
      wb_ready = 1'b0;
      check("op_done_in_budget", done, 1'b1);
      if (rd == 0 || mode == 1) check("idle_edge", edges, exp_lat);
      else check("wb_seen", wb_seen, 1'b1);
      if (rd == 0 || mode == 1) check("no_wb_valid", wb_seen, 1'b0);

      if (unit) m_runs++;
      if (unit && mode != 1) begin
         m_last_lat    = waits + 1;
         m_cache_valid = 1;
         m_cf3 = f3; m_ca = a; m_cb = b;
         if (waits >= int'(WAIT_LIMIT)) m_err = 1;
      end
      check("wb_valid_after", wb_valid, 1'b0);
      check("req_ready_after", req_ready, 1'b1);
      check("last_latency", last_latency, m_last_lat);
      check("err_timeout", err_timeout, m_err);
      check("unit_runs", unit_runs, m_runs);
      check("sb_empty", sb.size(), 0);
   endtask

   initial begin
      logic [2:0]  f3, pf3;
      logic [31:0] a, b, pa, pb;
      int          waits, mode, fa;

      reset = 1'b1;
      req_valid = 1'b0; req_funct3 = '0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
      flush = 1'b0; wb_ready = 1'b0;
      repeat (2) @(negedge clock);
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_mu", {mu_enabled, mu_funct3, mu_rs1, mu_rs2}, 64'd0);
      check("rst_wb", {wb_valid, wb_rd, wb_data}, 64'd0);
      check("rst_status", {last_latency, err_timeout}, 64'd0);
      reset = 1'b0;

      // Directed cases
      run_op(3'd5, 32'd100, 32'd7, 5'd5, 33, 0, 0, 0);
      run_op(3'd4, 32'd5, 32'd0, 5'd3, 0, 0, 0, 1);
      run_op(3'd7, 32'd5, 32'd0, 5'd3, 0, 0, 0, 0);
      run_op(3'd4, INT_MIN, ALL_ONES, 5'd8, 0, 0, 0, 0);
      run_op(3'd6, INT_MIN, ALL_ONES, 5'd9, 0, 0, 0, 2);
      run_op(3'd0, 32'd3, 32'd4, 5'd10, 0, 0, 0, 5);
      run_op(3'd5, 32'd1000, 32'd9, 5'd11, 10, 1, 3, 0);
      run_op(3'd3, ALL_ONES, 32'd2, 5'd12, 4, 0, 0, 0);
      run_op(3'd3, ALL_ONES, 32'd2, 5'd13, 4, 0, 0, 0);
      run_op(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd0, 6, 0, 0, 0);
      run_op(3'd5, 32'd77, 32'd0, 5'd0, 0, 0, 0, 0);
      run_op(3'd2, 32'hF000_0001, 32'hFFFF_0000, 5'd14, 2, 2, 0, 0);

      // Random traffic with occasional exact repeats
      pf3 = 3'd0; pa = 32'd1; pb = 32'd1;
      for (int i = 0; i < 40; i++) begin
         f3 = 3'($urandom);
         a  = pick_operand();
         b  = pick_operand();
         if ($urandom % 4 == 0) begin f3 = pf3; a = pa; b = pb; end
         waits = $urandom % 20;
         mode  = ($urandom % 8 == 0) ? 1 : (($urandom % 8 == 0) ? 2 : 0);
         fa    = 1 + $urandom_range(0, (waits > 0) ? waits - 1 : 0);
         run_op(f3, a, b, 5'($urandom), waits, mode, fa, $urandom % 4);
         pf3 = f3; pa = a; pb = b;
      end

      // Unit stalls past the limit
      run_op(3'd0, 32'd123, 32'd456, 5'd20, 70, 0, 0, 0);

      // Asynchronous reset in the middle of a unit op
      @(negedge clock);
      cur_f3 = 3'd0; cur_a = 32'd7; cur_b = 32'd9; plan_waits = 20;
      req_valid = 1'b1; req_funct3 = 3'd0; req_rs1 = 32'd7; req_rs2 = 32'd9; req_rd = 5'd4;
      @(posedge clock);
      #1 req_valid = 1'b0;
      repeat (3) @(posedge clock);
      #3 reset = 1'b1;
      #1;
      m_runs++;
      m_err = 0; m_last_lat = 0; m_cache_valid = 0;
      check("midrst_busy", busy, 1'b0);
      check("midrst_req_ready", req_ready, 1'b1);
      check("midrst_mu", {mu_enabled, mu_rs1, mu_rs2}, 64'd0);
      check("midrst_wb", {wb_valid, wb_data}, 64'd0);
      check("midrst_status", {last_latency, err_timeout}, 64'd0);
      @(negedge clock);
      reset = 1'b0;

      // Cache must be empty again after reset
      run_op(3'd3, ALL_ONES, 32'd2, 5'd15, 1, 0, 0, 0);

      repeat (2) @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
